muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file read ports. It takes the two source operands, runs a fixed-latency shift-add multiply or restoring divide, and presents the result, destination register index and a one-cycle write strobe. These feed the register file's write port (`wd3`, `a3`, `we`). The core stalls on `busy`.

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// over operand magnitudes, followed by one sign-fix cycle. Fixed XLEN+2 latency.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int N    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [N-1:0]    rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [N-1:0]    rd_out
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t          state;
    op_t             op;
    logic [CW-1:0]   count;
    logic [N-1:0]    rd_q;
    logic            neg_a;
    logic            neg_b;
    logic            b_zero;
    logic [XLEN-1:0] mag_b;
    // Multiply: {acc_hi, acc_lo} is the product, acc_lo starts as multiplier.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;

    // Operand sign/magnitude decode at capture time.
    logic            a_signed_in;
    logic            b_signed_in;
    logic            a_neg_in;
    logic            b_neg_in;
    logic [XLEN-1:0] a_mag_in;
    logic [XLEN-1:0] b_mag_in;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_signed_in = 1'b0;
        b_signed_in = 1'b0;
        case (op_t'(funct3))
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed_in = 1'b1;
                b_signed_in = 1'b1;
            end
            OP_MULHSU: a_signed_in = 1'b1;
            default: ;
        endcase
        a_neg_in = a_signed_in & a[XLEN-1];
        b_neg_in = b_signed_in & b[XLEN-1];
        a_mag_in = a_neg_in ? -a : a;
        b_mag_in = b_neg_in ? -b : b;
    end

    // One iteration of each algorithm.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_b : '0)};
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b};
    end

    // Sign correction and result selection.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        prod = {acc_hi, acc_lo};
        if (neg_a ^ neg_b) prod = -prod;
        quo = acc_lo;
        if (b_zero)             quo = '1;
        else if (neg_a ^ neg_b) quo = -acc_lo;
        // A zero divisor leaves |a| in the remainder, so this also returns a unchanged.
        rem = neg_a ? -acc_hi : acc_hi;
        fix_result = '0;
        case (op)
            OP_MUL:                       fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quo;
            default:                      fix_result = rem;
        endcase
    end

    // NOTE: only control state and the visible outputs are reset; the datapath
    // registers are always loaded at capture before being read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op     <= op_t'(funct3);
                        rd_q   <= rd_in;
                        neg_a  <= a_neg_in;
                        neg_b  <= b_neg_in;
                        b_zero <= (b == '0);
                        mag_b  <= b_mag_in;
                        acc_hi <= '0;
                        acc_lo <= a_mag_in;
                        count  <= CW'(XLEN - 1);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (op[2]) begin
                        acc_hi <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                    count <= count - 1'b1;
                    if (count == '0) state <= FIX;
                end
                FIX: begin
                    result <= fix_result;
                    rd_out <= rd_q;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
